// File: rtl/program_loader_pkg.sv
// Shared definitions for the Xenyx-4 program loader: defaults, state encoding and sizing helper.
package program_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned INSTR_W_DEF   = 16;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned TIMEOUT_DEF   = 100000;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } load_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte idle counter: clears on demand or when disabled, pulses expire on the
// TIMEOUT_CYC-th consecutive enabled idle cycle.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the expiry cycle suppresses the pulse: the arriving byte wins.
  always_comb begin
    expire = en && !clr && (cnt_q == LAST);
    cnt_d  = cnt_q + CW'(1);
    if (clr || !en || expire) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/program_loader.sv
// Frames a host byte stream into instruction words, writes them to instruction memory
// and holds the core in reset until a checksum-verified image is loaded.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned INSTR_W     = INSTR_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam int unsigned BPW   = INSTR_W / 8;
  localparam int unsigned IDX_W = idx_width(BPW);
  localparam int unsigned CNT_W = (ADDR_W + 1 > 8) ? ADDR_W + 1 : 8;
  localparam logic [CNT_W-1:0] FULL_WORDS = CNT_W'(2 ** ADDR_W);

  load_state_e        state_q, state_d;
  logic               rx_ready_q, rx_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
  logic               core_hold_q, core_hold_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   words_q, words_d;

  logic               acc;
  logic               tmo_en;
  logic               tmo_expire;
  logic [INSTR_W-1:0] word_nx;

  assign acc    = rx_valid && rx_ready_q;
  assign tmo_en = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (tmo_en),
    .clr    (acc),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d      = state_q;
    rx_ready_d   = 1'b1;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d  = core_hold_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    word_d       = word_q;
    csum_d       = csum_q;
    idx_d        = idx_q;
    words_d      = words_q;
    word_nx      = INSTR_W'({word_q, rx_data});

    // imem_addr doubles as the address pointer: it advances once the write cycle ends.
    if (imem_we_q) imem_addr_d = imem_addr_q + ADDR_W'(1);

    unique case (state_q)
      ST_SYNC, ST_DONE, ST_ERR: begin
        if (acc && rx_data == SYNC_BYTE) begin
          state_d     = ST_LEN;
          imem_addr_d = '0;
          csum_d      = '0;
          idx_d       = '0;
          core_hold_d = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
        end
      end
      ST_LEN: begin
        if (acc) begin
          words_d = (rx_data == 8'd0) ? FULL_WORDS : CNT_W'(rx_data);
          csum_d  = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (acc) begin
          word_d = word_nx;
          csum_d = csum_q ^ rx_data;
          if (idx_q == IDX_W'(BPW - 1)) begin
            idx_d        = '0;
            imem_we_d    = 1'b1;
            imem_wdata_d = word_nx;
            words_d      = words_q - CNT_W'(1);
            if (words_q == CNT_W'(1)) state_d = ST_CSUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (acc) begin
          if (csum_q == rx_data) begin
            state_d     = ST_DONE;
            load_done_d = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            state_d    = ST_ERR;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (tmo_expire) begin
      state_d    = ST_ERR;
      load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SYNC;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      word_q       <= '0;
      csum_q       <= '0;
      idx_q        <= '0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, checksum, timeout, wrap, reset and reload.
module tb_program_loader;

  localparam int unsigned TCYC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  wa[$];
  logic [15:0] wd[$];

  program_loader #(
    .INSTR_W     (16),
    .ADDR_W      (8),
    .TIMEOUT_CYC (TCYC),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, rx_ready, 0);
    check_eq({tag, "_we"},    imem_we, 0);
    check_eq({tag, "_addr"},  imem_addr, 0);
    check_eq({tag, "_wdata"}, imem_wdata, 0);
    check_eq({tag, "_hold"},  core_hold, 1);
    check_eq({tag, "_done"},  load_done, 0);
    check_eq({tag, "_err"},   load_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bad;
    logic [7:0] cs;
    logic [7:0] hi;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    idle(1);
    check_eq("ready_after_rst", rx_ready, 1);

    // T1: good two-word frame
    clear_log();
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB);
    check_eq("t1_hold_mid", core_hold, 1);
    send_byte(8'hCD);
    check_eq("t1_we_lat", imem_we, 1);
    check_eq("t1_we_addr", imem_addr, 8'h01);
    check_eq("t1_we_data", imem_wdata, 16'hABCD);
    send_byte(8'h40);
    check_eq("t1_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      check_eq("t1_a0", wa[0], 8'h00);
      check_eq("t1_d0", wd[0], 16'h1234);
      check_eq("t1_a1", wa[1], 8'h01);
      check_eq("t1_d1", wd[1], 16'hABCD);
    end
    check_eq("t1_done", load_done, 1);
    check_eq("t1_hold", core_hold, 0);
    check_eq("t1_err", load_err, 0);
    check_eq("t1_addr_after", imem_addr, 8'h02);

    // T2: bad checksum, then sync clears the error
    clear_log();
    send_byte(8'hA5);
    check_eq("t2_reload_hold", core_hold, 1);
    check_eq("t2_reload_done", load_done, 0);
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h41);
    check_eq("t2_nwr", wa.size(), 2);
    check_eq("t2_err", load_err, 1);
    check_eq("t2_hold", core_hold, 1);
    check_eq("t2_done", load_done, 0);
    send_byte(8'hA5);
    check_eq("t2_err_clr", load_err, 0);

    // T3: timeout mid-frame (already in LEN)
    clear_log();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01);
    idle(TCYC - 1);
    check_eq("t3_err_early", load_err, 0);
    idle(1);
    check_eq("t3_err", load_err, 1);
    idle(5);
    check_eq("t3_nwr", wa.size(), 1);
    if (wa.size() == 1) check_eq("t3_d0", wd[0], 16'h0001);

    // T3b: byte on the expiry cycle wins
    clear_log();
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h01);
    idle(TCYC - 1);
    send_byte(8'h02);
    check_eq("t3b_no_err", load_err, 0);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h01);
    check_eq("t3b_done", load_done, 1);
    check_eq("t3b_err", load_err, 0);
    check_eq("t3b_nwr", wa.size(), 3);
    if (wa.size() == 3) check_eq("t3b_d1", wd[1], 16'h0203);

    // T4: LEN=0 loads 256 words and wraps the address
    clear_log();
    send_byte(8'hA5); send_byte(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      send_byte(hi);
      send_byte(~hi ^ 8'h3C);
      cs = cs ^ hi ^ (~hi ^ 8'h3C);
    end
    send_byte(cs);
    check_eq("t4_nwr", wa.size(), 256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      if (i >= wa.size()) bad++;
      else if (wa[i] !== hi || wd[i] !== {hi, ~hi ^ 8'h3C}) bad++;
    end
    check_eq("t4_seq_bad", bad, 0);
    if (wa.size() == 256) check_eq("t4_last_addr", wa[255], 8'hFF);
    check_eq("t4_addr_wrap", imem_addr, 8'h00);
    check_eq("t4_done", load_done, 1);
    check_eq("t4_hold", core_hold, 0);

    // T5: reset after 3 of 5 words
    clear_log();
    send_byte(8'hA5); send_byte(8'h05);
    for (int i = 0; i < 6; i++) send_byte(8'(i + 8'h10));
    rst = 1'b1;
    idle(1);
    check_reset_outputs("t5_rst");
    check_eq("t5_nwr", wa.size(), 3);
    rst = 1'b0;
    idle(1);
    clear_log();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h51);
    check_eq("t5_done", load_done, 1);
    check_eq("t5_nwr2", wa.size(), 1);
    if (wa.size() == 1) check_eq("t5_d0", wd[0], 16'hBEEF);

    // T6: junk before sync, then reload from DONE
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    clear_log();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(2);
    check_eq("t6_junk_nwr", wa.size(), 0);
    check_eq("t6_junk_hold", core_hold, 1);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h26);
    check_eq("t6_done", load_done, 1);
    check_eq("t6_hold_rel", core_hold, 0);
    send_byte(8'h00);
    check_eq("t6_done_junk_hold", core_hold, 0);
    clear_log();
    send_byte(8'hA5);
    check_eq("t6_reload_hold", core_hold, 1);
    check_eq("t6_reload_done", load_done, 0);
    send_byte(8'h01);
    send_byte(8'h56); send_byte(8'h78);
    check_eq("t6_hold_pre_csum", core_hold, 1);
    send_byte(8'h2E);
    check_eq("t6_reload_rel", core_hold, 0);
    check_eq("t6_reload_ok", load_done, 1);
    if (wa.size() == 1) check_eq("t6_d0", wd[0], 16'h5678);
    else check_eq("t6_nwr", wa.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
